// File: rtl/rom_loader.sv
// rom_loader: UART byte stream -> Hack instruction ROM writer.
// Frame: SYNC, LEN_HI, LEN_LO, N words (hi byte first), CHK (mod-256 sum of data bytes).
// Ports: i_CLK/i_RESET clock and async reset; i_Byte/i_Byte_Valid byte strobe in;
//   o_Write_EN/o_Address/o_Data ROM write port; o_CPU_Hold CPU reset request;
//   o_Busy frame in progress; o_Done image verified; o_Error 01 chk, 10 timeout, 11 length.
module rom_loader #(
  parameter int          ADDR_WIDTH     = 15,
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                  i_CLK,
  input  logic                  i_RESET,
  input  logic [7:0]            i_Byte,
  input  logic                  i_Byte_Valid,
  output logic                  o_Write_EN,
  output logic [ADDR_WIDTH-1:0] o_Address,
  output logic [15:0]           o_Data,
  output logic                  o_CPU_Hold,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic [1:0]            o_Error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI,
    S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [16:0]           cnt_q, cnt_d;
  logic [7:0]            hi_q, hi_d;
  logic [7:0]            chk_q, chk_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] wa_d;
  logic [15:0]           wd_d;
  logic                  we_d;
  logic [1:0]            err_q, err_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic                  active;
  logic [15:0]           n_w;

  assign active = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                  (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                  (state_q == S_CHECK);
  assign n_w = {len_q[15:8], i_Byte};

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      chk_q      <= '0;
      addr_q     <= '0;
      o_Address  <= '0;
      o_Data     <= '0;
      o_Write_EN <= 1'b0;
      err_q      <= '0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      chk_q      <= chk_d;
      addr_q     <= addr_d;
      o_Address  <= wa_d;
      o_Data     <= wd_d;
      o_Write_EN <= we_d;
      err_q      <= err_d;
      tmr_q      <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    chk_d   = chk_q;
    addr_d  = addr_q;
    wa_d    = o_Address;
    wd_d    = o_Data;
    we_d    = 1'b0;
    err_d   = err_q;
    tmr_d   = tmr_q;

    if (active) begin
      tmr_d = i_Byte_Valid ? '0 : tmr_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_Byte_Valid && i_Byte == SYNC_BYTE) begin
          state_d = S_LEN_HI;
          err_d   = 2'b00;
          addr_d  = '0;
          chk_d   = '0;
          cnt_d   = '0;
          tmr_d   = '0;
        end
      end
      S_LEN_HI: begin
        if (i_Byte_Valid) begin
          len_d[15:8] = i_Byte;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (i_Byte_Valid) begin
          len_d[7:0] = i_Byte;
          if ({1'b0, n_w} > CAP) begin
            state_d = S_ERROR;
            err_d   = 2'b11;
          end else if (n_w == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (i_Byte_Valid) begin
          hi_d    = i_Byte;
          chk_d   = chk_q + i_Byte;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (i_Byte_Valid) begin
          chk_d  = chk_q + i_Byte;
          we_d   = 1'b1;
          wa_d   = addr_q;
          wd_d   = {hi_q, i_Byte};
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q + 17'd1;
          if (cnt_q + 17'd1 == {1'b0, len_q}) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_CHECK: begin
        if (i_Byte_Valid) begin
          if (i_Byte == chk_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERROR;
            err_d   = 2'b01;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Silence inside a frame overrides whatever the byte path decided.
    if (active && !i_Byte_Valid && tmr_q == TMAX) begin
      state_d = S_ERROR;
      err_d   = 2'b10;
    end
  end

  assign o_Busy     = active;
  assign o_CPU_Hold = active || (state_q == S_ERROR);
  assign o_Done     = (state_q == S_DONE);
  assign o_Error    = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized frames vs. a frame-level reference model.
// Expected writes go into a scoreboard queue; a forked monitor checks them.
module tb_rom_loader;

  localparam int AW = 4;
  localparam int TO = 100;
  localparam int CAPW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    byte_in;
  logic          valid;
  logic          we;
  logic [AW-1:0] addr;
  logic [15:0]   data;
  logic          hold;
  logic          busy;
  logic          done;
  logic [1:0]    err;

  rom_loader #(
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .i_CLK(clk),
    .i_RESET(rst),
    .i_Byte(byte_in),
    .i_Byte_Valid(valid),
    .o_Write_EN(we),
    .o_Address(addr),
    .o_Data(data),
    .o_CPU_Hold(hold),
    .o_Busy(busy),
    .o_Done(done),
    .o_Error(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         e;
  logic [15:0] words_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic chk_status(input string name, input bit x_done,
                            input logic [1:0] x_err, input bit x_hold,
                            input bit x_busy);
    chk({name, "_status"}, {done, err, hold, busy},
        {x_done, x_err, x_hold, x_busy});
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0h data=%h, required none",
                   addr, data);
        end else begin
          e = exp_q.pop_front();
          if (e.a !== addr || e.d !== data) begin
            errors++;
            $display("FAIL write: got addr=%0h data=%h, required addr=%0h data=%h",
                     addr, data, e.a, e.d);
          end
        end
        chk("write_pulse_single", {31'd0, prev_we}, 32'd0);
      end
      prev_we = we;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    byte_in = b;
    valid   = 1'b1;
    @(negedge clk);
    valid   = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_stray(input int k);
    logic [7:0] b;
    for (int i = 0; i < k; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h55;
      send_byte(b, $urandom_range(0, 2));
    end
  endtask

  // Frame-level model: n words, checksum = byte sum mod 256.
  // chk_ovr < 0 sends the correct checksum, bad=1 a corrupted one.
  task automatic run_frame(input string name, input int n, input bit bad,
                           input int chk_ovr);
    logic [7:0] sum;
    logic [7:0] cb;
    wr_t        w;
    sum = 8'd0;
    while (words_q.size() < n) words_q.push_back(16'($urandom));
    for (int i = 0; i < n; i++) begin
      sum = sum + words_q[i][15:8] + words_q[i][7:0];
      if (n <= CAPW) begin
        w.a = AW'(i % CAPW);
        w.d = words_q[i];
        exp_q.push_back(w);
      end
    end
    send_byte(8'hA5, 0);
    chk_status({name, "_sync"}, 1'b0, 2'b00, 1'b1, 1'b1);
    send_byte(8'(n >> 8), $urandom_range(0, 2));
    send_byte(8'(n), 0);
    if (n > CAPW) begin
      chk_status({name, "_len_ovf"}, 1'b0, 2'b11, 1'b1, 1'b0);
      words_q.delete();
      return;
    end
    for (int i = 0; i < n; i++) begin
      send_byte(words_q[i][15:8], $urandom_range(0, 2));
      send_byte(words_q[i][7:0], $urandom_range(0, 2));
    end
    if (chk_ovr >= 0) cb = 8'(chk_ovr);
    else if (bad) cb = sum + 8'($urandom_range(1, 255));
    else cb = sum;
    send_byte(cb, 1);
    if (cb == sum) chk_status(name, 1'b1, 2'b00, 1'b0, 1'b0);
    else chk_status(name, 1'b0, 2'b01, 1'b1, 1'b0);
    chk({name, "_writes_drained"}, exp_q.size(), 0);
    words_q.delete();
  endtask

  initial begin
    wr_t w;
    rst     = 1'b1;
    byte_in = 8'h00;
    valid   = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("reset_outputs", {we, addr, data, hold, busy, done, err}, 0);
    rst = 1'b0;
    @(negedge clk);

    send_byte(8'h55, 0);
    send_byte(8'hFF, 0);
    chk_status("stray_ignored", 1'b0, 2'b00, 1'b0, 1'b0);
    words_q = '{16'h1234, 16'hABCD};
    run_frame("two_words", 2, 1'b0, -1);

    words_q = '{16'h1234, 16'hABCD};
    run_frame("bad_chk", 2, 1'b0, 8'h0F);

    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    repeat (TO - 1) @(negedge clk);
    chk_status("timeout_early", 1'b0, 2'b00, 1'b1, 1'b1);
    @(negedge clk);
    chk_status("timeout", 1'b0, 2'b10, 1'b1, 1'b0);

    run_frame("len_ovf", CAPW + 1, 1'b0, -1);
    run_frame("full_cap", CAPW, 1'b0, -1);

    send_byte(8'h55, 0);
    send_byte(8'hFF, 0);
    run_frame("empty", 0, 1'b0, -1);

    words_q = '{16'hA5A5, 16'h00A5, 16'hA500};
    run_frame("sync_as_data", 3, 1'b0, -1);

    w.a = '0;
    w.d = 16'h1234;
    exp_q.push_back(w);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", {we, addr, data, hold, busy, done, err}, 0);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    send_byte(8'hBE, 1);
    chk_status("after_reset_idle", 1'b0, 2'b00, 1'b0, 1'b0);
    chk("after_reset_drained", exp_q.size(), 0);
    words_q = '{16'h1234, 16'hABCD};
    run_frame("reload", 2, 1'b0, -1);

    for (int k = 0; k < 12; k++) begin
      send_stray($urandom_range(0, 3));
      run_frame("rand", $urandom_range(0, CAPW + 2),
                $urandom_range(0, 3) == 0, -1);
    end

    repeat (4) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
